// File: rtl/irq_prio_rr_arbiter_pkg.sv
// Shared types and constants for the priority / round-robin interrupt arbiter.
package irq_prio_rr_arbiter_pkg;

  localparam int unsigned DefaultPrioW = 3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StService = 2'd2
  } arb_state_e;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_rr_arbiter_select.sv
// Combinational winner pick: highest priority, ties resolved by circular scan from i_rr_ptr.
module irq_prio_rr_arbiter_select
  import irq_prio_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INT_PORTS = 16,
  parameter int unsigned PRIO_W        = DefaultPrioW,
  parameter int unsigned ID_W          = id_w(NUM_INT_PORTS)
) (
  input  logic [NUM_INT_PORTS-1:0]        i_cand,
  input  logic [NUM_INT_PORTS*PRIO_W-1:0] i_prio,
  input  logic [ID_W-1:0]                 i_rr_ptr,
  output logic                            o_found,
  output logic [ID_W-1:0]                 o_win_id,
  output logic [PRIO_W-1:0]               o_win_prio
);

  logic              w_found;
  logic [ID_W-1:0]   w_win_id;
  logic [PRIO_W-1:0] w_win_prio;

  // Visiting sources in rotated order makes a strict '>' keep the first tie after rr_ptr.
  always_comb begin
    logic [ID_W:0]   v_sum;
    logic [ID_W-1:0] v_idx;
    w_found    = 1'b0;
    w_win_id   = '0;
    w_win_prio = '0;
    v_sum      = '0;
    v_idx      = '0;
    for (int unsigned j = 0; j < NUM_INT_PORTS; j++) begin
      v_sum = {1'b0, i_rr_ptr} + (ID_W+1)'(j);
      if (v_sum >= (ID_W+1)'(NUM_INT_PORTS)) begin
        v_sum = v_sum - (ID_W+1)'(NUM_INT_PORTS);
      end
      v_idx = v_sum[ID_W-1:0];
      if (i_cand[v_idx] && (!w_found || (i_prio[v_idx*PRIO_W +: PRIO_W] > w_win_prio))) begin
        w_found    = 1'b1;
        w_win_id   = v_idx;
        w_win_prio = i_prio[v_idx*PRIO_W +: PRIO_W];
      end
    end
  end

  assign o_found    = w_found;
  assign o_win_id   = w_win_id;
  assign o_win_prio = w_win_prio;

endmodule

// File: rtl/irq_prio_rr_arbiter.sv
// Interrupt arbiter: per-source edge/level latching, enable, priority, threshold,
// round-robin tie break and a single in-service ACK/EOI handshake.
module irq_prio_rr_arbiter
  import irq_prio_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INT_PORTS = 16,
  parameter int unsigned PRIO_W        = DefaultPrioW,
  parameter int unsigned ID_W          = id_w(NUM_INT_PORTS)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_INT_PORTS-1:0]        IRQ,
  input  logic [NUM_INT_PORTS-1:0]        IRQ_EDGE,
  input  logic [NUM_INT_PORTS-1:0]        IRQ_EN,
  input  logic [NUM_INT_PORTS*PRIO_W-1:0] IRQ_PRIO,
  input  logic [PRIO_W-1:0]               THRESH,
  output logic                            IRQ_VLD,
  output logic [ID_W-1:0]                 IRQ_ID,
  output logic [PRIO_W-1:0]               IRQ_PRIO_OUT,
  input  logic                            IRQ_ACK,
  input  logic                            IRQ_EOI,
  output logic                            IN_SERVICE,
  output logic [NUM_INT_PORTS-1:0]        PENDING
);

  arb_state_e r_state, w_state_next;

  logic [NUM_INT_PORTS-1:0] r_irq_q, r_pend, w_pend_next, w_cand;
  logic [ID_W-1:0]          r_id, r_rr_ptr, w_win_id;
  logic [PRIO_W-1:0]        r_prio, w_win_prio;
  logic                     w_found, w_ack, w_load;

  assign w_ack  = (r_state == StPresent) && IRQ_ACK;
  assign w_load = (r_state == StIdle) && w_found;

  // r_id doubles as the in-service id: it is frozen from presentation until EOI.
  always_comb begin
    w_pend_next = '0;
    w_cand      = '0;
    for (int i = 0; i < NUM_INT_PORTS; i++) begin
      if (IRQ_EDGE[i]) begin
        w_pend_next[i] = (IRQ[i] & ~r_irq_q[i]) | (r_pend[i] & ~(w_ack && (r_id == ID_W'(i))));
      end else begin
        w_pend_next[i] = IRQ[i];
      end
      w_cand[i] = r_pend[i] && IRQ_EN[i] && (IRQ_PRIO[i*PRIO_W +: PRIO_W] > THRESH) &&
                  !((r_state == StService) && (r_id == ID_W'(i)));
    end
  end

  irq_prio_rr_arbiter_select #(
    .NUM_INT_PORTS(NUM_INT_PORTS),
    .PRIO_W       (PRIO_W),
    .ID_W         (ID_W)
  ) u_select (
    .i_cand    (w_cand),
    .i_prio    (IRQ_PRIO),
    .i_rr_ptr  (r_rr_ptr),
    .o_found   (w_found),
    .o_win_id  (w_win_id),
    .o_win_prio(w_win_prio)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_found) w_state_next = StPresent;
      StPresent: begin
        if (IRQ_ACK) begin
          w_state_next = StService;
        end else if (!w_cand[r_id]) begin
          w_state_next = StIdle;
        end
      end
      StService: if (IRQ_EOI) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    IRQ_VLD    = (r_state == StPresent);
    IN_SERVICE = (r_state == StService);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_irq_q  <= '0;
      r_pend   <= '0;
      r_id     <= '0;
      r_prio   <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_irq_q <= IRQ;
      r_pend  <= w_pend_next;
      if (w_load) begin
        r_id   <= w_win_id;
        r_prio <= w_win_prio;
      end
      if (w_ack) begin
        r_rr_ptr <= (r_id == ID_W'(NUM_INT_PORTS - 1)) ? '0 : r_id + 1'b1;
      end
    end
  end

  assign IRQ_ID       = r_id;
  assign IRQ_PRIO_OUT = r_prio;
  assign PENDING      = r_pend;

endmodule

// File: tb/tb_irq_prio_rr_arbiter.sv
// Directed self-checking bench for irq_prio_rr_arbiter (16 sources, 3-bit priority).
module tb_irq_prio_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IRQ, IRQ_EDGE, IRQ_EN, PENDING;
  logic [47:0] prio_v;
  logic [2:0]  THRESH, IRQ_PRIO_OUT;
  logic [3:0]  IRQ_ID;
  logic        IRQ_VLD, IRQ_ACK, IRQ_EOI, IN_SERVICE;

  int n_vec = 0;
  int n_err = 0;

  irq_prio_rr_arbiter #(
    .NUM_INT_PORTS(16),
    .PRIO_W       (3)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IRQ         (IRQ),
    .IRQ_EDGE    (IRQ_EDGE),
    .IRQ_EN      (IRQ_EN),
    .IRQ_PRIO    (prio_v),
    .THRESH      (THRESH),
    .IRQ_VLD     (IRQ_VLD),
    .IRQ_ID      (IRQ_ID),
    .IRQ_PRIO_OUT(IRQ_PRIO_OUT),
    .IRQ_ACK     (IRQ_ACK),
    .IRQ_EOI     (IRQ_EOI),
    .IN_SERVICE  (IN_SERVICE),
    .PENDING     (PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_prio(input int src, input logic [2:0] p);
    prio_v[src*3 +: 3] = p;
  endtask

  int exp_ids[4] = '{1, 4, 7, 1};

  initial begin
    // Reset with all lines high
    RST = 1'b0; IRQ = '1; IRQ_EDGE = '0; IRQ_EN = '1; prio_v = {16{3'd1}};
    THRESH = 3'd0; IRQ_ACK = 1'b0; IRQ_EOI = 1'b0;
    step(); step();
    chk("rst_vld", IRQ_VLD, 0);
    chk("rst_id", IRQ_ID, 0);
    chk("rst_insvc", IN_SERVICE, 0);
    chk("rst_pend", PENDING, 0);
    RST = 1'b1;
    step();
    chk("rel_pend", PENDING, 16'hffff);
    chk("rel_vld_early", IRQ_VLD, 0);
    step();
    chk("rel_vld", IRQ_VLD, 1);
    chk("rel_id", IRQ_ID, 0);
    chk("rel_prio", IRQ_PRIO_OUT, 1);

    // Priority: src3 prio5 beats src9 prio2
    RST = 1'b0; #1;
    IRQ = '0; IRQ_EDGE = '1; prio_v = '0; set_prio(3, 5); set_prio(9, 2);
    step(); RST = 1'b1;
    IRQ[3] = 1'b1; IRQ[9] = 1'b1;
    step();
    chk("pri_pend", PENDING, 16'h0208);
    chk("pri_vld_early", IRQ_VLD, 0);
    step();
    chk("pri_vld", IRQ_VLD, 1);
    chk("pri_id", IRQ_ID, 3);
    chk("pri_prio", IRQ_PRIO_OUT, 5);
    IRQ = '0; IRQ_ACK = 1'b1;
    step();
    chk("pri_ack_vld", IRQ_VLD, 0);
    chk("pri_ack_insvc", IN_SERVICE, 1);
    chk("pri_ack_pend", PENDING, 16'h0200);
    IRQ_ACK = 1'b0; IRQ_EOI = 1'b1;
    step();
    chk("pri_eoi_insvc", IN_SERVICE, 0);
    chk("pri_eoi_vld", IRQ_VLD, 0);
    IRQ_EOI = 1'b0;
    step();
    chk("pri2_vld", IRQ_VLD, 1);
    chk("pri2_id", IRQ_ID, 9);
    chk("pri2_prio", IRQ_PRIO_OUT, 2);
    IRQ_ACK = 1'b1; step(); IRQ_ACK = 1'b0; IRQ_EOI = 1'b1; step(); IRQ_EOI = 1'b0;

    // Round robin among level sources 1,4,7 at prio3; rr_ptr is now 10
    IRQ_EDGE = '0; set_prio(1, 3); set_prio(4, 3); set_prio(7, 3);
    IRQ = 16'h0092;
    step();
    chk("rr_pend", PENDING, 16'h0092);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("rr_vld", IRQ_VLD, 1);
      chk("rr_id", IRQ_ID, exp_ids[k]);
      IRQ_ACK = 1'b1;
      step();
      chk("rr_insvc", IN_SERVICE, 1);
      chk("rr_svc_vld", IRQ_VLD, 0);
      IRQ_ACK = 1'b0; IRQ_EOI = 1'b1;
      step();
      chk("rr_eoi_insvc", IN_SERVICE, 0);
      IRQ_EOI = 1'b0;
      step();
    end
    chk("rr_next_id", IRQ_ID, 4);
    // Level source drops while presented: withdrawn one cycle after pending clears
    IRQ = '0;
    step();
    chk("lvl_drop_vld_hold", IRQ_VLD, 1);
    step();
    chk("lvl_drop_vld", IRQ_VLD, 0);
    chk("lvl_drop_insvc", IN_SERVICE, 0);

    // Withdraw by disable
    IRQ_EDGE = 16'h0040; set_prio(6, 6); IRQ = 16'h0040;
    step();
    IRQ = '0;
    step();
    chk("wd_vld", IRQ_VLD, 1);
    chk("wd_id", IRQ_ID, 6);
    IRQ_EN[6] = 1'b0;
    step();
    chk("wd_vld_off", IRQ_VLD, 0);
    chk("wd_insvc", IN_SERVICE, 0);
    chk("wd_pend", PENDING, 16'h0040);
    IRQ_EN[6] = 1'b1;
    step();
    chk("wd_re_vld", IRQ_VLD, 1);
    chk("wd_re_id", IRQ_ID, 6);
    IRQ_ACK = 1'b1; step(); IRQ_ACK = 1'b0; IRQ_EOI = 1'b1; step(); IRQ_EOI = 1'b0;

    // New edge in the ACK cycle; ACK+EOI together in PRESENT acts as ACK
    IRQ_EDGE = 16'h0004; set_prio(2, 4); IRQ = 16'h0004;
    step();
    IRQ = '0;
    step();
    chk("eda_id", IRQ_ID, 2);
    IRQ = 16'h0004; IRQ_ACK = 1'b1; IRQ_EOI = 1'b1;
    step();
    chk("eda_pend", PENDING, 16'h0004);
    chk("eda_insvc", IN_SERVICE, 1);
    IRQ = '0; IRQ_ACK = 1'b0;
    step();
    chk("eda_eoi_insvc", IN_SERVICE, 0);
    IRQ_EOI = 1'b0;
    step();
    chk("eda_re_vld", IRQ_VLD, 1);
    chk("eda_re_id", IRQ_ID, 2);
    IRQ_ACK = 1'b1; step(); IRQ_ACK = 1'b0; IRQ_EOI = 1'b1; step(); IRQ_EOI = 1'b0;

    // Threshold, stray handshakes, async reset mid-service
    THRESH = 3'd4; IRQ_EDGE = 16'h0020; set_prio(5, 4); IRQ = 16'h0020;
    step();
    IRQ = '0;
    step(); step();
    chk("thr_vld", IRQ_VLD, 0);
    chk("thr_pend", PENDING, 16'h0020);
    IRQ_EOI = 1'b1;
    step();
    chk("stray_eoi_vld", IRQ_VLD, 0);
    chk("stray_eoi_insvc", IN_SERVICE, 0);
    IRQ_EOI = 1'b0; THRESH = 3'd3;
    step();
    chk("thr_lo_vld", IRQ_VLD, 1);
    chk("thr_lo_id", IRQ_ID, 5);
    chk("thr_lo_prio", IRQ_PRIO_OUT, 4);
    IRQ_ACK = 1'b1;
    step();
    chk("svc_insvc", IN_SERVICE, 1);
    step();
    chk("stray_ack_insvc", IN_SERVICE, 1);
    chk("stray_ack_vld", IRQ_VLD, 0);
    RST = 1'b0; #1;
    chk("arst_insvc", IN_SERVICE, 0);
    chk("arst_vld", IRQ_VLD, 0);
    chk("arst_id", IRQ_ID, 0);
    chk("arst_pend", PENDING, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
